// File: rtl/seven_segment_scan_decoder.sv
// Receive-side monitor for a multiplexed 4-digit seven-segment bus.
// Samples the active-low anode/segment lines, waits for each an/seg pair to
// hold steady, then decodes the segment pattern back to a BCD digit for the
// lit position. A frame strobe marks the point where every position has been
// captured since the previous strobe.
module seven_segment_scan_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [7:0]  seg,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic [3:0]  dp,
    output logic        frame_strobe,
    output logic        err_pattern,
    output logic        err_anode
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [3:0]       s_an_q, s_an_d;
    logic [7:0]       s_seg_q, s_seg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             captured_q, captured_d;
    logic [3:0]       seen_q, seen_d;
    logic [15:0]      digits_q, digits_d;
    logic [3:0]       valid_q, valid_d;
    logic [3:0]       dp_q, dp_d;
    logic             strobe_q, strobe_d;
    logic             err_pat_q, err_pat_d;
    logic             err_an_q, err_an_d;

    logic [3:0]       dec_val;
    logic             dec_legal;
    logic             dec_blank;
    logic             same;
    logic             capture;
    logic [3:0]       an_low;
    logic             one_hot;
    logic             multi;
    logic [3:0]       seen_new;

    // Map the sampled segment code (g..a, active low) back to a BCD digit.
    always_comb begin
        dec_val   = 4'hF;
        dec_legal = 1'b0;
        dec_blank = 1'b0;
        case (s_seg_q[6:0])
            7'h40: begin dec_val = 4'd0; dec_legal = 1'b1; end
            7'h79: begin dec_val = 4'd1; dec_legal = 1'b1; end
            7'h24: begin dec_val = 4'd2; dec_legal = 1'b1; end
            7'h30: begin dec_val = 4'd3; dec_legal = 1'b1; end
            7'h19: begin dec_val = 4'd4; dec_legal = 1'b1; end
            7'h12: begin dec_val = 4'd5; dec_legal = 1'b1; end
            7'h02: begin dec_val = 4'd6; dec_legal = 1'b1; end
            7'h78: begin dec_val = 4'd7; dec_legal = 1'b1; end
            7'h00: begin dec_val = 4'd8; dec_legal = 1'b1; end
            7'h10: begin dec_val = 4'd9; dec_legal = 1'b1; end
            7'h7F: dec_blank = 1'b1;
            default: ;
        endcase
    end

    // Stability tracking, one-shot capture and per-position update.
    always_comb begin
        s_an_d     = an;
        s_seg_d    = seg;
        cnt_d      = cnt_q;
        captured_d = captured_q;
        seen_d     = seen_q;
        digits_d   = digits_q;
        valid_d    = valid_q;
        dp_d       = dp_q;
        strobe_d   = 1'b0;
        err_pat_d  = 1'b0;
        err_an_d   = 1'b0;
        seen_new   = seen_q;

        same    = ({an, seg} == {s_an_q, s_seg_q});
        capture = (cnt_q == CNT_LAST) && !captured_q;
        an_low  = ~s_an_q;
        one_hot = (an_low != 4'd0) && ((an_low & (an_low - 4'd1)) == 4'd0);
        multi   = (an_low != 4'd0) && !one_hot;

        if (!same) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // A changing input re-arms capture even on the edge that captures,
        // otherwise the very next hold would be ignored.
        if (!same) begin
            captured_d = 1'b0;
        end else if (capture) begin
            captured_d = 1'b1;
        end

        if (capture) begin
            if (one_hot) begin
                seen_new = seen_q | an_low;
                if (seen_new == 4'hF) begin
                    strobe_d = 1'b1;
                    seen_d   = 4'd0;
                end else begin
                    seen_d   = seen_new;
                end
                for (int p = 0; p < 4; p++) begin
                    if (an_low[p]) begin
                        digits_d[4*p +: 4] = dec_val;
                        valid_d[p]         = dec_legal;
                        dp_d[p]            = ~s_seg_q[7];
                    end
                end
                err_pat_d = !dec_legal && !dec_blank;
            end else if (multi) begin
                err_an_d = 1'b1;
            end
        end
    end

    // State register; reset discards any partial hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_an_q     <= 4'hF;
            s_seg_q    <= 8'hFF;
            cnt_q      <= '0;
            captured_q <= 1'b0;
            seen_q     <= 4'd0;
            digits_q   <= 16'hFFFF;
            valid_q    <= 4'd0;
            dp_q       <= 4'd0;
            strobe_q   <= 1'b0;
            err_pat_q  <= 1'b0;
            err_an_q   <= 1'b0;
        end else begin
            s_an_q     <= s_an_d;
            s_seg_q    <= s_seg_d;
            cnt_q      <= cnt_d;
            captured_q <= captured_d;
            seen_q     <= seen_d;
            digits_q   <= digits_d;
            valid_q    <= valid_d;
            dp_q       <= dp_d;
            strobe_q   <= strobe_d;
            err_pat_q  <= err_pat_d;
            err_an_q   <= err_an_d;
        end
    end

    assign digits       = digits_q;
    assign digit_valid  = valid_q;
    assign dp           = dp_q;
    assign frame_strobe = strobe_q;
    assign err_pattern  = err_pat_q;
    assign err_anode    = err_an_q;

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Bench for seven_segment_scan_decoder: directed scan sequences, a stream-level
// reference model checked every cycle, and hand-computed literal expectations.
module tb_seven_segment_scan_decoder;

    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  an = 4'hF;
    logic [7:0]  seg = 8'hFF;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic [3:0]  dp;
    logic        frame_strobe;
    logic        err_pattern;
    logic        err_anode;

    seven_segment_scan_decoder #(.STABLE_CYCLES(STABLE), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .an(an), .seg(seg),
        .digits(digits), .digit_valid(digit_valid), .dp(dp),
        .frame_strobe(frame_strobe), .err_pattern(err_pattern), .err_anode(err_anode)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int n_strobe = 0;
    int n_errp = 0;
    int n_erra = 0;
    int snap_s, snap_e;

    // Reference model state
    logic [6:0]  code_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                   7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [3:0]  m_dig [4];
    logic [3:0]  m_valid, m_dp, m_seen;
    logic        m_strobe, m_errp, m_erra;
    logic [11:0] m_prev;
    int          m_run;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int p = 0; p < 4; p++) m_dig[p] = 4'hF;
        m_valid = 4'd0; m_dp = 4'd0; m_seen = 4'd0;
        m_strobe = 1'b0; m_errp = 1'b0; m_erra = 1'b0;
        m_prev = 12'hFFF;
        m_run = 1;
    endtask

    // One clock edge of the model: the sampled stream is a run of identical
    // values; a run that has just reached STABLE samples is captured.
    task automatic model_step(input logic [3:0] a, input logic [7:0] s);
        logic [3:0] ca;
        logic [7:0] cs;
        int zeros, pos, found;
        m_strobe = 1'b0; m_errp = 1'b0; m_erra = 1'b0;
        if (m_run == STABLE) begin
            ca = m_prev[11:8];
            cs = m_prev[7:0];
            zeros = 0; pos = 0;
            for (int i = 0; i < 4; i++) if (!ca[i]) begin zeros++; pos = i; end
            if (zeros == 1) begin
                found = -1;
                for (int d = 0; d < 10; d++) if (code_tbl[d] == cs[6:0]) found = d;
                m_dp[pos] = !cs[7];
                if (found >= 0) begin
                    m_dig[pos] = 4'(found); m_valid[pos] = 1'b1;
                end else begin
                    m_dig[pos] = 4'hF; m_valid[pos] = 1'b0;
                    m_errp = (cs[6:0] != 7'h7F);
                end
                m_seen[pos] = 1'b1;
                if (m_seen == 4'hF) begin
                    m_strobe = 1'b1; m_seen = 4'd0;
                end
            end else if (zeros >= 2) begin
                m_erra = 1'b1;
            end
        end
        if ({a, s} == m_prev) begin
            if (m_run <= STABLE) m_run++;
        end else begin
            m_run = 1;
        end
        m_prev = {a, s};
    endtask

    // Model advances on each edge; reset clears it asynchronously.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step(an, seg);
        end
    end

    // Every-cycle comparison against the model, plus pulse counting.
    initial begin
        forever begin
            @(negedge clk);
            chk("digits", digits, {m_dig[3], m_dig[2], m_dig[1], m_dig[0]});
            chk("digit_valid", 16'(digit_valid), 16'(m_valid));
            chk("dp", 16'(dp), 16'(m_dp));
            chk("frame_strobe", 16'(frame_strobe), 16'(m_strobe));
            chk("err_pattern", 16'(err_pattern), 16'(m_errp));
            chk("err_anode", 16'(err_anode), 16'(m_erra));
            if (frame_strobe) n_strobe++;
            if (err_pattern) n_errp++;
            if (err_anode) n_erra++;
        end
    end

    task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
        an = a;
        seg = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic gap();
        hold(4'hF, 8'hFF, 3);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_digits", digits, 16'hFFFF);
        chk("reset_valid", 16'(digit_valid), 16'h0);

        // 1: single digit '2' at position 0
        hold(4'b1110, 8'hA4, 4);
        hold(4'hF, 8'hFF, 2);
        chk("t1_digit0", 16'(digits[3:0]), 16'd2);
        chk("t1_valid", 16'(digit_valid), 16'b0001);
        chk("t1_dp0", 16'(dp[0]), 16'd0);
        chk("t1_model_digit0", 16'(m_dig[0]), 16'd2);
        chk("t1_strobes", 16'(n_strobe), 16'd0);

        // 2: full scan 1,2,3,4
        snap_s = n_strobe;
        hold(4'b1110, 8'hF9, 6); gap();
        hold(4'b1101, 8'hA4, 6); gap();
        hold(4'b1011, 8'hB0, 6); gap();
        hold(4'b0111, 8'h99, 6); gap();
        chk("t2_digits", digits, 16'h4321);
        chk("t2_valid", 16'(digit_valid), 16'hF);
        chk("t2_strobes", 16'(n_strobe - snap_s), 16'd1);

        // 3: blank code with decimal point, then dp off
        snap_e = n_errp;
        hold(4'b1101, 8'h7F, 5);
        chk("t3_digits", digits, 16'h43F1);
        chk("t3_valid", 16'(digit_valid), 16'b1101);
        chk("t3_dp1_on", 16'(dp[1]), 16'd1);
        hold(4'b1101, 8'hFF, 5);
        chk("t3_dp1_off", 16'(dp[1]), 16'd0);
        chk("t3_no_err", 16'(n_errp - snap_e), 16'd0);

        // 4: short hold ignored, long hold captured once
        hold(4'b0111, 8'hC0, 3); gap();
        chk("t4_short", digits, 16'h43F1);
        hold(4'b0111, 8'hC0, 100);
        hold(4'hF, 8'hFF, 2);
        chk("t4_long", digits, 16'h03F1);

        // 5: anode and pattern errors
        snap_e = n_erra;
        hold(4'b1100, 8'hC0, 6); gap();
        chk("t5_err_anode", 16'(n_erra - snap_e), 16'd1);
        chk("t5_unchanged", digits, 16'h03F1);
        snap_e = n_errp;
        hold(4'b1110, 8'hFE, 6); gap();
        chk("t5_err_pattern", 16'(n_errp - snap_e), 16'd1);
        chk("t5_valid", 16'(digit_valid), 16'b1100);
        chk("t5_digits", digits, 16'h03FF);

        // 6: finish frame, then reset mid-hold
        snap_s = n_strobe;
        hold(4'b1011, 8'h92, 6); gap();
        chk("t6_frame", 16'(n_strobe - snap_s), 16'd1);
        chk("t6_digits", digits, 16'h05FF);
        hold(4'b1110, 8'hC0, 2);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_digits", digits, 16'hFFFF);
        chk("t6_rst_valid", 16'(digit_valid), 16'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        snap_s = n_strobe;
        hold(4'b1110, 8'hC0, 6); gap();
        hold(4'b1101, 8'hF9, 6); gap();
        hold(4'b1011, 8'hA4, 6); gap();
        chk("t6_no_early_frame", 16'(n_strobe - snap_s), 16'd0);
        hold(4'b0111, 8'hB0, 6); gap();
        chk("t6_new_frame", 16'(n_strobe - snap_s), 16'd1);
        chk("t6_new_digits", digits, 16'h3210);
        chk("t6_new_valid", 16'(digit_valid), 16'hF);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
